// File: rtl/nukv_arb_pkg.sv
// Shared definitions for the nukv stream arbiters: FSM encoding and counter widths.
package nukv_arb_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // Burst beat counter width; BURST_LEN must fit in it.
    localparam int unsigned CNT_W  = 8;
    // Width of each statistics counter.
    localparam int unsigned STAT_W = 32;

endpackage

// File: rtl/nukv_rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping modulo NUM_IN.
module nukv_rr_pick #(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned ID_BITS = 2
) (
    input  logic [NUM_IN-1:0]  req_i,
    input  logic [ID_BITS-1:0] last_i,
    output logic [ID_BITS-1:0] idx_o,
    output logic               any_o
);

    // Scan last+1 .. last+NUM_IN; the final candidate is 'last' itself.
    always_comb begin : pick
        int unsigned cand;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            cand = (32'(last_i) + k) % NUM_IN;
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = ID_BITS'(cand);
            end
        end
    end

endmodule

// File: rtl/nukv_stream_rr_arbiter.sv
// Round-robin burst arbiter sharing one stream sink between NUM_IN requesters.
// Each output beat carries its source index on m_axis_tid. New bursts are held off
// while the downstream FIFO signals almost-full.
// Optional: define NUKV_ARB_STATS_EN to add per-requester beat counters and an
// almost-full stall counter.
module nukv_stream_rr_arbiter
    import nukv_arb_pkg::*;
#(
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned ID_BITS   = 2
) (
    input  logic                          s_axis_clk,
    input  logic                          s_axis_rst,
    input  logic [NUM_IN*DATA_SIZE-1:0]   s_axis_tdata,
    input  logic [NUM_IN-1:0]             s_axis_tvalid,
    output logic [NUM_IN-1:0]             s_axis_tready,
    output logic [DATA_SIZE-1:0]          m_axis_tdata,
    output logic [ID_BITS-1:0]            m_axis_tid,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic                          m_axis_talmostfull,
    output logic                          grant_active
`ifdef NUKV_ARB_STATS_EN
    ,
    output logic [NUM_IN*STAT_W-1:0]      stat_beats,
    output logic [STAT_W-1:0]             stat_af_stall
`endif
);

    arb_state_e           state_q, state_d;
    logic [ID_BITS-1:0]   grant_q, grant_d;
    logic [ID_BITS-1:0]   last_q, last_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     count_inc;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [ID_BITS-1:0]   tid_q, tid_d;
    logic                 valid_q, valid_d;

    logic                 load;
    logic                 cur_valid;
    logic [DATA_SIZE-1:0] cur_data;
    logic                 accept;
    logic [ID_BITS-1:0]   pick_idx;
    logic                 pick_any;

    nukv_rr_pick #(
        .NUM_IN  (NUM_IN),
        .ID_BITS (ID_BITS)
    ) u_pick (
        .req_i  (s_axis_tvalid),
        .last_i (last_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Datapath view of the granted requester and the output-register load enable.
    always_comb begin
        load      = m_axis_tready | ~valid_q;
        cur_valid = s_axis_tvalid[grant_q];
        cur_data  = s_axis_tdata[32'(grant_q) * DATA_SIZE +: DATA_SIZE];
        accept    = (state_q == StGrant) & load & cur_valid;
        count_inc = count_q + CNT_W'(1);
    end

    // Only the granted requester sees ready, and only when the output register can load.
    always_comb begin
        s_axis_tready = '0;
        if (state_q == StGrant && load) begin
            s_axis_tready[grant_q] = 1'b1;
        end
    end

    // Arbitration FSM: one idle cycle to pick, then stream up to BURST_LEN beats.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any && !m_axis_talmostfull) begin
                    grant_d = pick_idx;
                    count_d = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (accept) begin
                    count_d = count_inc;
                    if (count_inc == CNT_W'(BURST_LEN)) begin
                        state_d = StIdle;
                        last_d  = grant_q;
                    end
                end else if (load && !cur_valid) begin
                    // Requester ran dry; a stalled sink (load=0) never ends a burst.
                    state_d = StIdle;
                    last_d  = grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output pipeline register: holds data/tid stable until the sink takes it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tid_d   = tid_q;
        if (load) begin
            valid_d = accept;
            if (accept) begin
                data_d = cur_data;
                tid_d  = grant_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge s_axis_clk or negedge s_axis_rst) begin
        if (!s_axis_rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= ID_BITS'(NUM_IN - 1);
            count_q <= '0;
            data_q  <= '0;
            tid_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
            data_q  <= data_d;
            tid_q   <= tid_d;
            valid_q <= valid_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tvalid = valid_q;
    assign grant_active  = (state_q == StGrant);

`ifdef NUKV_ARB_STATS_EN
    logic [STAT_W-1:0] beats_q [NUM_IN];
    logic [STAT_W-1:0] beats_d [NUM_IN];
    logic [STAT_W-1:0] stall_q, stall_d;

    // Per-requester accepted-beat counters and almost-full stall counter.
    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            beats_d[i] = beats_q[i];
            if (accept && grant_q == ID_BITS'(i)) begin
                beats_d[i] = beats_q[i] + STAT_W'(1);
            end
        end
        stall_d = stall_q;
        if (state_q == StIdle && pick_any && m_axis_talmostfull) begin
            stall_d = stall_q + STAT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge s_axis_clk or negedge s_axis_rst) begin
        if (!s_axis_rst) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                beats_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                beats_q[i] <= beats_d[i];
            end
            stall_q <= stall_d;
        end
    end

    // Flatten the per-requester counters onto the output bus.
    always_comb begin
        stat_beats = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            stat_beats[i*STAT_W +: STAT_W] = beats_q[i];
        end
    end

    assign stat_af_stall = stall_q;
`endif

endmodule

// File: tb/tb_nukv_stream_rr_arbiter.sv
// Self-checking bench for nukv_stream_rr_arbiter (NUM_IN=4, DATA_SIZE=16, BURST_LEN=8).
// Accepted input beats are pushed to per-source expected queues; output beats are
// popped by tid and compared. Build with NUKV_ARB_STATS_EN to also check the counters.
module tb_nukv_stream_rr_arbiter;

    localparam int NUM_IN    = 4;
    localparam int DATA_SIZE = 16;
    localparam int BURST_LEN = 8;
    localparam int ID_BITS   = 2;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NUM_IN*DATA_SIZE-1:0] s_tdata = '0;
    logic [NUM_IN-1:0]           s_tvalid = '0;
    logic [NUM_IN-1:0]           s_tready;
    logic [DATA_SIZE-1:0]        m_tdata;
    logic [ID_BITS-1:0]          m_tid;
    logic                        m_tvalid;
    logic                        m_tready = 1'b1;
    logic                        m_af = 1'b0;
    logic                        grant_active;
`ifdef NUKV_ARB_STATS_EN
    logic [NUM_IN*32-1:0]        stat_beats;
    logic [31:0]                 stat_af_stall;
`endif

    always #5 clk = ~clk;

    nukv_stream_rr_arbiter #(
        .NUM_IN    (NUM_IN),
        .DATA_SIZE (DATA_SIZE),
        .BURST_LEN (BURST_LEN),
        .ID_BITS   (ID_BITS)
    ) dut (
        .s_axis_clk         (clk),
        .s_axis_rst         (rst_n),
        .s_axis_tdata       (s_tdata),
        .s_axis_tvalid      (s_tvalid),
        .s_axis_tready      (s_tready),
        .m_axis_tdata       (m_tdata),
        .m_axis_tid         (m_tid),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tready      (m_tready),
        .m_axis_talmostfull (m_af),
        .grant_active       (grant_active)
`ifdef NUKV_ARB_STATS_EN
        ,
        .stat_beats         (stat_beats),
        .stat_af_stall      (stat_af_stall)
`endif
    );

    logic [DATA_SIZE-1:0] src_q [NUM_IN][$];
    logic [DATA_SIZE-1:0] exp_q [NUM_IN][$];
    logic [NUM_IN-1:0]    en = '0;
    int                   hs_cnt [NUM_IN];
    int                   out_tid [$];
    int                   out_cyc [$];
    logic [DATA_SIZE-1:0] out_data [$];
    int                   total = 0;
    int                   bad = 0;
    int                   cyc = 0;

    task automatic drive_sources();
        for (int i = 0; i < NUM_IN; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i*DATA_SIZE +: DATA_SIZE] = src_q[i][0];
            end else begin
                s_tvalid[i] = 1'b0;
            end
        end
    endtask

    // One clock: drive sources, record handshakes and score output beats at negedge.
    task automatic tick();
        logic [DATA_SIZE-1:0] e;
        drive_sources();
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    exp_q[i].push_back(src_q[i].pop_front());
                    hs_cnt[i]++;
                end
            end
            if (m_tvalid && m_tready) begin
                total++;
                if (exp_q[m_tid].size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard: got data=%h tid=%0d, required no beat", m_tdata, m_tid);
                end else begin
                    e = exp_q[m_tid].pop_front();
                    if (m_tdata !== e) begin
                        bad++;
                        $display("FAIL scoreboard: tid=%0d data=%h required %h", m_tid, m_tdata, e);
                    end
                end
                out_tid.push_back(int'(m_tid));
                out_data.push_back(m_tdata);
                out_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic int exp_pending();
        int n = 0;
        for (int i = 0; i < NUM_IN; i++) n += exp_q[i].size();
        return n;
    endfunction

    task automatic clear_logs();
        for (int i = 0; i < NUM_IN; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            hs_cnt[i] = 0;
        end
        out_tid.delete();
        out_cyc.delete();
        out_data.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        m_tready = 1'b1;
        while ((grant_active || m_tvalid || exp_pending() != 0) && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total += 5;
        if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: %b required 0", m_tvalid); end
        if (m_tdata !== '0) begin bad++; $display("FAIL reset_tdata: %h required 0", m_tdata); end
        if (m_tid !== '0) begin bad++; $display("FAIL reset_tid: %0d required 0", m_tid); end
        if (s_tready !== '0) begin bad++; $display("FAIL reset_tready: %b required 0000", s_tready); end
        if (grant_active !== 1'b0) begin bad++; $display("FAIL reset_grant: %b required 0", grant_active); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (grant_active !== 1'b0) begin bad++; $display("FAIL idle_no_req: grant_active=%b required 0", grant_active); end
    endtask

    task automatic test_fairness();
        int start;
        int n = 0;
        int errs = 0;
        clear_logs();
        for (int i = 0; i < NUM_IN; i++)
            for (int k = 0; k < 16; k++) src_q[i].push_back(16'(i * 256 + k));
        en = 4'hF;
        start = cyc;
        while (out_tid.size() < 64 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (out_tid.size() != 64) begin
            bad++;
            $display("FAIL rr_beats: %0d beats required 64", out_tid.size());
        end else begin
            for (int b = 0; b < 64; b++) begin
                total++;
                if (out_tid[b] != (b / 8) % 4) begin
                    bad++;
                    $display("FAIL rr_tid: beat %0d tid=%0d required %0d", b, out_tid[b], (b / 8) % 4);
                end
            end
            total++;
            if (out_cyc[0] - start != 2) begin
                bad++;
                $display("FAIL rr_latency: %0d cycles required 2", out_cyc[0] - start);
            end
            for (int b = 1; b < 8; b++) begin
                total++;
                if (out_cyc[8*b] - out_cyc[8*b-1] != 2) begin
                    bad++;
                    $display("FAIL rr_gap: burst %0d gap=%0d required 2", b, out_cyc[8*b] - out_cyc[8*b-1]);
                end
            end
            for (int b = 1; b < 64; b++)
                if (b % 8 != 0 && out_cyc[b] - out_cyc[b-1] != 1) errs++;
            total++;
            if (errs != 0) begin bad++; $display("FAIL rr_contig: %0d bubbles required 0", errs); end
        end
        drain("rr");
`ifdef NUKV_ARB_STATS_EN
        for (int i = 0; i < NUM_IN; i++) begin
            total++;
            if (stat_beats[i*32 +: 32] !== 32'd16) begin
                bad++;
                $display("FAIL stat_beats: req %0d count=%0d required 16", i, stat_beats[i*32 +: 32]);
            end
        end
`endif
        en = '0;
    endtask

    task automatic test_single_dry();
        logic [DATA_SIZE-1:0] want [3];
        int start;
        int n = 0;
        want = '{16'h00A1, 16'h00A2, 16'h00A3};
        clear_logs();
        for (int k = 0; k < 3; k++) src_q[2].push_back(want[k]);
        en = 4'b0100;
        start = cyc;
        while (out_tid.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (out_tid.size() != 3) begin
            bad++;
            $display("FAIL dry_beats: %0d beats required 3", out_tid.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (out_tid[k] != 2 || out_data[k] !== want[k]) begin
                    bad++;
                    $display("FAIL dry_beat: %0d tid=%0d data=%h required tid=2 data=%h",
                             k, out_tid[k], out_data[k], want[k]);
                end
            end
            total++;
            if (out_cyc[0] - start != 2) begin
                bad++;
                $display("FAIL dry_latency: %0d cycles required 2", out_cyc[0] - start);
            end
        end
        tick();
        tick();
        tick();
        total++;
        if (grant_active !== 1'b0 || m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL dry_end: grant_active=%b tvalid=%b required 0 0", grant_active, m_tvalid);
        end
        // Requesters 0 and 3 both pending: with last_grant=2 the search reaches 3 first.
        clear_logs();
        src_q[0].push_back(16'h00B0);
        src_q[3].push_back(16'h00B3);
        en = 4'b1001;
        n = 0;
        while (out_tid.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (out_tid.size() != 2 || out_tid[0] != 3 || out_tid[1] != 0) begin
            bad++;
            $display("FAIL dry_last_grant: %0d beats first tid=%0d required 2 beats first tid=3",
                     out_tid.size(), (out_tid.size() > 0) ? out_tid[0] : -1);
        end
        drain("dry");
        en = '0;
    endtask

    task automatic test_backpressure();
        logic                 pat [4];
        logic                 pv = 1'b0;
        logic                 pr = 1'b1;
        logic [DATA_SIZE-1:0] pd = '0;
        logic [ID_BITS-1:0]   pt = '0;
        logic                 pga = 1'b0;
        int                   falls = 0;
        int                   k = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        clear_logs();
        for (int j = 0; j < 10; j++) src_q[1].push_back(16'(16'h1000 + j));
        en = 4'b0010;
        while (k < 200 && !(out_tid.size() == 10 && !grant_active && !m_tvalid)) begin
            pv = m_tvalid;
            pd = m_tdata;
            pt = m_tid;
            m_tready = pat[k % 4];
            pr = m_tready;
            k++;
            tick();
            if (pv && !pr) begin
                total++;
                if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tid !== pt) begin
                    bad++;
                    $display("FAIL bp_hold: valid=%b data=%h tid=%0d required 1 %h %0d",
                             m_tvalid, m_tdata, m_tid, pd, pt);
                end
            end
            if (pga && !grant_active) falls++;
            pga = grant_active;
        end
        m_tready = 1'b1;
        total++;
        if (out_data.size() != 10) begin
            bad++;
            $display("FAIL bp_beats: %0d beats required 10", out_data.size());
        end else begin
            for (int j = 0; j < 10; j++) begin
                total++;
                if (out_data[j] !== 16'(16'h1000 + j)) begin
                    bad++;
                    $display("FAIL bp_order: beat %0d data=%h required %h", j, out_data[j], 16'(16'h1000 + j));
                end
            end
        end
        total++;
        if (falls != 2) begin bad++; $display("FAIL bp_bursts: %0d burst ends required 2", falls); end
        drain("bp");
        en = '0;
    endtask

    task automatic test_almost_full();
        int n = 0;
        int rises = 0;
        logic pga;
        clear_logs();
        for (int j = 0; j < 16; j++) src_q[0].push_back(16'(16'h2000 + j));
        en = 4'b0001;
        while (hs_cnt[0] < 4 && n < 50) begin
            tick();
            n++;
        end
        m_af = 1'b1;
        pga = grant_active;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (!pga && grant_active) rises++;
            pga = grant_active;
        end
        total += 3;
        if (hs_cnt[0] != 8) begin bad++; $display("FAIL af_finish: %0d beats accepted required 8", hs_cnt[0]); end
        if (rises != 0) begin bad++; $display("FAIL af_block: %0d new grants required 0", rises); end
        if (grant_active !== 1'b0 || out_tid.size() != 8) begin
            bad++;
            $display("FAIL af_idle: grant_active=%b out=%0d required 0 8", grant_active, out_tid.size());
        end
        m_af = 1'b0;
        tick();
        total++;
        if (grant_active !== 1'b1) begin bad++; $display("FAIL af_release: grant_active=%b required 1", grant_active); end
        n = 0;
        while (out_tid.size() < 16 && n < 50) begin
            tick();
            n++;
        end
        drain("af");
        total++;
        if (out_tid.size() != 16) begin bad++; $display("FAIL af_total: %0d beats required 16", out_tid.size()); end
        en = '0;
    endtask

`ifdef NUKV_ARB_STATS_EN
    task automatic test_stats_stall();
        logic [31:0] s0;
        clear_logs();
        s0 = stat_af_stall;
        src_q[1].push_back(16'h5555);
        en = 4'b0010;
        m_af = 1'b1;
        for (int j = 0; j < 10; j++) tick();
        total++;
        if (stat_af_stall - s0 !== 32'd10) begin
            bad++;
            $display("FAIL stat_af_stall: delta=%0d required 10", stat_af_stall - s0);
        end
        m_af = 1'b0;
        drain("stall");
        en = '0;
    endtask
`endif

    task automatic test_reset_mid_burst();
        int n = 0;
        clear_logs();
        for (int j = 0; j < 8; j++) src_q[1].push_back(16'(16'h3000 + j));
        en = 4'b0010;
        while (hs_cnt[1] < 3 && n < 50) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        total += 3;
        if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_tvalid: %b required 0", m_tvalid); end
        if (s_tready !== '0) begin bad++; $display("FAIL mid_rst_tready: %b required 0000", s_tready); end
        if (grant_active !== 1'b0) begin bad++; $display("FAIL mid_rst_grant: %b required 0", grant_active); end
        en = '0;
        clear_logs();
        drive_sources();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_IN; i++) src_q[i].push_back(16'(16'h4000 + i));
        en = 4'hF;
        n = 0;
        while (out_tid.size() < 4 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (out_tid.size() != 4) begin
            bad++;
            $display("FAIL mid_rst_beats: %0d beats required 4", out_tid.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (out_tid[i] != i) begin
                    bad++;
                    $display("FAIL mid_rst_order: beat %0d tid=%0d required %0d", i, out_tid[i], i);
                end
            end
        end
        drain("mid_rst");
        en = '0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_dry();
        test_backpressure();
        test_almost_full();
`ifdef NUKV_ARB_STATS_EN
        test_stats_stall();
`endif
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
